// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous memory.
// Each granted access takes three cycles: ACC (strobe issued), RESP (memory
// answers), then a done pulse in the following cycle. Ties are broken in favour
// of the requester that was not served last.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata       requester A access request and payload
//   a_gnt/a_done/a_rdata            requester A grant pulse, done pulse, read data
//   b_*                             same set for requester B
//   read/write/addr/data_in         memory strobes, address and write data
//   data_out                        memory read data, valid the cycle after read
//   busy                            high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              we_q, we_d;          // latched access type
  logic              owner_b_q, owner_b_d;  // 1: current access belongs to B
  logic              last_b_q, last_b_d;    // 1: B was granted most recently

  logic a_elig_s, b_elig_s, win_a_s, win_b_s;

  // A requester still showing req in its own done cycle is not a new request.
  assign a_elig_s = a_req & ~a_done_q;
  assign b_elig_s = b_req & ~b_done_q;
  assign win_a_s  = a_elig_s & (~b_elig_s | last_b_q);
  assign win_b_s  = b_elig_s & (~a_elig_s | ~last_b_q);

  assign a_gnt   = a_gnt_q;
  assign b_gnt   = b_gnt_q;
  assign a_done  = a_done_q;
  assign b_done  = b_done_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign read    = read_q;
  assign write   = write_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;
  assign busy    = busy_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a grant from IDLE always takes exactly ACC then RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_elig_s || b_elig_s) begin
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: outputs are registered, so each value is set one edge
  // ahead of the cycle it belongs to
  always_comb begin
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    we_d      = we_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (win_a_s) begin
          owner_b_d = 1'b0;
          last_b_d  = 1'b0;
          we_d      = a_we;
          addr_d    = a_addr;
          data_in_d = a_wdata;
          a_gnt_d   = 1'b1;
          write_d   = a_we;
          read_d    = ~a_we;
        end else if (win_b_s) begin
          owner_b_d = 1'b1;
          last_b_d  = 1'b1;
          we_d      = b_we;
          addr_d    = b_addr;
          data_in_d = b_wdata;
          b_gnt_d   = 1'b1;
          write_d   = b_we;
          read_d    = ~b_we;
        end else begin
          owner_b_d = owner_b_q;
        end
      end
      ACC: begin
        // strobes fall back to their defaults; address and data hold
        we_d = we_q;
      end
      RESP: begin
        // data_out is valid now, one cycle after the read strobe was sampled
        if (owner_b_q) begin
          b_done_d = 1'b1;
          if (!we_q) begin
            b_rdata_d = data_out;
          end else begin
            b_rdata_d = b_rdata_q;
          end
        end else begin
          a_done_d = 1'b1;
          if (!we_q) begin
            a_rdata_d = data_out;
          end else begin
            a_rdata_d = a_rdata_q;
          end
        end
      end
      default: begin
        we_d = we_q;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      data_in_q <= {DATA_W{1'b0}};
      a_rdata_q <= {DATA_W{1'b0}};
      b_rdata_q <= {DATA_W{1'b0}};
      we_q      <= 1'b0;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      read_q    <= read_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      we_q      <= we_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model and a behavioural memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = 5'd0, b_addr = 5'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;
  logic       a_gnt, a_done, b_gnt, b_done, read, write, busy;
  logic [7:0] a_rdata, b_rdata, data_in;
  logic [7:0] data_out;
  logic [4:0] addr;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_init(int i);
    return 8'(i * 29 + 17);
  endfunction

  // Behavioural memory: contents restored on reset, read data registered
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= mem_init(i);
      data_out <= 8'h00;
    end else begin
      if (write) mem[addr] <= data_in;
      if (read) data_out <= mem[addr];
    end
  end

  // ---------------- reference model (transaction level) ----------------
  // m_age: -1 no access in flight, otherwise cycles elapsed since the grant.
  int         m_age = -1;
  bit         m_owner_b, m_we, m_last_b = 1'b1, m_a_done, m_b_done;
  logic [4:0] m_addr = 5'd0;
  logic [7:0] m_wdata = 8'd0, m_a_rdata = 8'd0, m_b_rdata = 8'd0;
  logic [7:0] mmem [32];

  task automatic model_update();
    bit ae, be, wb;
    if (reset) begin
      m_age = -1; m_a_done = 1'b0; m_b_done = 1'b0; m_last_b = 1'b1;
      m_addr = 5'd0; m_wdata = 8'd0; m_a_rdata = 8'd0; m_b_rdata = 8'd0;
      for (int i = 0; i < 32; i++) mmem[i] = mem_init(i);
    end else begin
      ae = a_req && !m_a_done;
      be = b_req && !m_b_done;
      m_a_done = 1'b0;
      m_b_done = 1'b0;
      if (m_age == 1) begin
        if (m_owner_b) m_b_done = 1'b1; else m_a_done = 1'b1;
        if (!m_we) begin
          if (m_owner_b) m_b_rdata = mmem[m_addr]; else m_a_rdata = mmem[m_addr];
        end
        m_age = -1;
      end else if (m_age == 0) begin
        if (m_we) mmem[m_addr] = m_wdata;
        m_age = 1;
      end else if (ae || be) begin
        wb = be && (!ae || !m_last_b);
        m_owner_b = wb;
        m_last_b  = wb;
        m_we    = wb ? b_we : a_we;
        m_addr  = wb ? b_addr : a_addr;
        m_wdata = wb ? b_wdata : a_wdata;
        m_age = 0;
      end
    end
  endtask

  // One clock: inputs are stable across the edge, outputs observed at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Let outstanding requests finish, dropping each req in its done cycle.
  task automatic drain();
    for (int c = 0; c < 8; c++) begin
      step();
      if (a_done) a_req = 1'b0;
      if (b_done) b_req = 1'b0;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, read, write, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {a_gnt, b_gnt, a_done, b_done, read, write, busy});
    end
    checks++;
    if ({addr, data_in, a_rdata, b_rdata} !== 29'd0) begin
      errors++;
      $display("FAIL reset_data: addr %0h data_in %0h a_rdata %0h b_rdata %0h expected all 0",
               addr, data_in, a_rdata, b_rdata);
    end
  endtask

  task automatic test_write_a();
    int gc = -1, dc = -1, wc = 0, rc = 0;
    a_we = 1'b1; a_addr = 5'd3; a_wdata = 8'hA5; a_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (a_gnt) gc = c;
      if (read) rc++;
      if (write) begin
        wc++;
        checks++;
        if (addr !== 5'd3 || data_in !== 8'hA5) begin
          errors++;
          $display("FAIL write_bus: addr %0h data_in %0h expected 3 a5", addr, data_in);
        end
      end
      if (a_done) begin dc = c; a_req = 1'b0; end
    end
    checks++;
    if (wc !== 1 || rc !== 0) begin
      errors++;
      $display("FAIL write_strobe_count: write %0d read %0d expected 1 0", wc, rc);
    end
    checks++;
    if (gc !== 0 || dc !== 2) begin
      errors++;
      $display("FAIL write_latency: gnt cycle %0d done cycle %0d expected 0 2", gc, dc);
    end
  endtask

  task automatic test_read_a();
    int dc = -1, rc = 0;
    a_we = 1'b0; a_addr = 5'd3; a_wdata = 8'h00; a_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (read) rc++;
      if (a_done) begin
        dc = c; a_req = 1'b0;
        checks++;
        if (a_rdata !== 8'hA5) begin
          errors++;
          $display("FAIL read_data: got %0h expected a5", a_rdata);
        end
      end
    end
    checks++;
    if (rc !== 1 || dc !== 2) begin
      errors++;
      $display("FAIL read_timing: read count %0d done cycle %0d expected 1 2", rc, dc);
    end
  endtask

  task automatic test_tie();
    int ga = -1, gb = -1, ovl = 0, bd = -1;
    do_reset();
    a_we = 1'b1; a_addr = 5'd1; a_wdata = 8'h5A;
    b_we = 1'b0; b_addr = 5'd2;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (a_gnt && ga < 0) ga = c;
      if (b_gnt && gb < 0) gb = c;
      if (read && write) ovl++;
      if (a_done) a_req = 1'b0;
      if (b_done) begin
        b_req = 1'b0; bd = c;
        checks++;
        if (b_rdata !== mem_init(2)) begin
          errors++;
          $display("FAIL tie_b_rdata: got %0h expected %0h", b_rdata, mem_init(2));
        end
      end
    end
    checks++;
    if (ga !== 0 || gb !== 3 || bd !== 5) begin
      errors++;
      $display("FAIL tie_order: a_gnt %0d b_gnt %0d b_done %0d expected 0 3 5", ga, gb, bd);
    end
    checks++;
    if (ovl !== 0) begin
      errors++;
      $display("FAIL tie_overlap: got %0d cycles expected 0", ovl);
    end
  endtask

  task automatic test_back_to_back();
    int gcyc[$];
    bit gwho[$];
    do_reset();
    a_we = 1'b0; a_addr = 5'd9;  b_we = 1'b1; b_addr = 5'd10; b_wdata = 8'h77;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (a_gnt) begin gcyc.push_back(c); gwho.push_back(1'b0); end
      if (b_gnt) begin gcyc.push_back(c); gwho.push_back(1'b1); end
      if (a_done) a_req = 1'b0; else a_req = 1'b1;
      if (b_done) b_req = 1'b0; else b_req = 1'b1;
    end
    drain();
    checks++;
    if (gcyc.size() < 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d grants expected at least 6", gcyc.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (gwho[k] !== bit'(k % 2) || gcyc[k] !== 3 * k) begin
          errors++;
          $display("FAIL b2b_grant%0d: who %0d cycle %0d expected %0d %0d",
                   k, gwho[k], gcyc[k], k % 2, 3 * k);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int bd = 0;
    do_reset();
    b_we = 1'b1; b_addr = 5'd7; b_wdata = 8'h3C; b_req = 1'b1;
    step();
    checks++;
    if (b_gnt !== 1'b1 || write !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: b_gnt %b write %b expected 1 1", b_gnt, write);
    end
    reset = 1'b1; b_req = 1'b0;
    step();
    checks++;
    if (write !== 1'b0 || busy !== 1'b0 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobe: write %b busy %b b_gnt %b expected 0 0 0", write, busy, b_gnt);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (b_done) bd++;
    end
    checks++;
    if (bd !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d b_done pulses expected 0", bd);
    end
    a_we = 1'b0; a_addr = 5'd4; b_we = 1'b0; b_addr = 5'd6;
    a_req = 1'b1; b_req = 1'b1;
    step();
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_tie: a_gnt %b b_gnt %b expected 1 0", a_gnt, b_gnt);
    end
    drain();
  endtask

  task automatic test_ignore();
    int agn = 0, bd = -1;
    b_we = 1'b0; b_addr = 5'd31; b_req = 1'b1;
    a_we = 1'b0; a_addr = 5'd5;
    for (int c = 0; c < 6; c++) begin
      step();
      if (a_gnt) agn++;
      if (c < 3) begin
        checks++;
        if (addr !== 5'd31) begin
          errors++;
          $display("FAIL ignore_addr%0d: got %0d expected 31", c, addr);
        end
      end
      if (b_done) begin
        bd = c; b_req = 1'b0;
        checks++;
        if (b_rdata !== mem_init(31)) begin
          errors++;
          $display("FAIL ignore_rdata: got %0h expected %0h", b_rdata, mem_init(31));
        end
      end
      a_req = (c == 0);  // toggles only while B's access is in flight
    end
    checks++;
    if (agn !== 0 || bd !== 2) begin
      errors++;
      $display("FAIL ignore_grant: a_gnt %0d b_done cycle %0d expected 0 2", agn, bd);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_ctrl;
    a_req = 1'b0; b_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      exp_ctrl = {m_age == 0 && !m_owner_b, m_age == 0 && m_owner_b, m_a_done, m_b_done,
                  m_age == 0 && !m_we, m_age == 0 && m_we, m_age >= 0};
      checks++;
      if ({a_gnt, b_gnt, a_done, b_done, read, write, busy} !== exp_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got %b expected %b", c,
                 {a_gnt, b_gnt, a_done, b_done, read, write, busy}, exp_ctrl);
      end
      checks++;
      if (addr !== m_addr || data_in !== m_wdata || a_rdata !== m_a_rdata || b_rdata !== m_b_rdata) begin
        errors++;
        $display("FAIL rand_data@%0d: got %0h %0h %0h %0h expected %0h %0h %0h %0h", c,
                 addr, data_in, a_rdata, b_rdata, m_addr, m_wdata, m_a_rdata, m_b_rdata);
      end
      if (a_req && a_done) a_req = 1'b0;
      else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_we = 1'($urandom_range(0, 1)); a_addr = 5'($urandom_range(0, 31));
        a_wdata = 8'($urandom_range(0, 255)); a_req = 1'b1;
      end
      if (b_req && b_done) b_req = 1'b0;
      else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_we = 1'($urandom_range(0, 1)); b_addr = 5'($urandom_range(0, 31));
        b_wdata = 8'($urandom_range(0, 255)); b_req = 1'b1;
      end
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_a();
    test_read_a();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
